// File: rtl/mux_serializer_if.sv
// Handshake bundle for mux_serializer: word load side and serial bit side.
// Also carries the registered word and select index that drive muxN.
interface mux_serializer_if #(
    parameter int N = 8
);
    localparam int SW = $clog2(N);

    logic          load_valid;
    logic          load_ready;
    logic [N-1:0]  data_in;
    logic          msb_first;
    logic [N-1:0]  data_q;
    logic [SW-1:0] ss;
    logic          bit_valid;
    logic          bit_ready;
    logic          bit_out;
    logic          bit_last;

    modport slave (
        input  load_valid, data_in, msb_first, bit_ready,
        output load_ready, data_q, ss, bit_valid, bit_out, bit_last
    );

    modport master (
        output load_valid, data_in, msb_first, bit_ready,
        input  load_ready, data_q, ss, bit_valid, bit_out, bit_last
    );
endinterface

// File: rtl/mux_serializer.sv
// Parallel-to-serial front end for muxN: latches a word and walks the
// select index across all N positions, one bit per output handshake.
module mux_serializer #(
    parameter int N = 8
) (
    input logic           clk,
    input logic           n_rst,
    mux_serializer_if.slave bus
);
    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] TOP = SW'(N - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state;
    logic [N-1:0]  data_q;
    logic [SW-1:0] ss;
    logic          dir;

    logic bit_valid;
    logic last;
    logic load_ready;
    logic load;
    logic step;

    assign bit_valid  = (state == SHIFT);
    assign last       = bit_valid && (ss == (dir ? '0 : TOP));
    assign load_ready = !bit_valid || (last && bus.bit_ready);
    assign load       = bus.load_valid && load_ready;
    assign step       = bit_valid && bus.bit_ready;

    // A load on the last-bit edge takes priority, giving back-to-back words.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            data_q <= '0;
            ss     <= '0;
            dir    <= 1'b0;
        end else if (load) begin
            state  <= SHIFT;
            data_q <= bus.data_in;
            dir    <= bus.msb_first;
            ss     <= bus.msb_first ? TOP : '0;
        end else if (step) begin
            if (last) begin
                state <= IDLE;
            end else if (dir) begin
                ss <= ss - SW'(1);
            end else begin
                ss <= ss + SW'(1);
            end
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.data_q     = data_q;
    assign bus.ss         = ss;
    assign bus.bit_valid  = bit_valid;
    assign bus.bit_out    = data_q[ss];
    assign bus.bit_last   = last;
endmodule

// File: tb/tb_mux_serializer.sv
// Self-checking bench for mux_serializer: vector table, corner sequences,
// and a randomized run against a queue-based reference model.
module tb_mux_serializer;
    logic clk = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    mux_serializer_if #(.N(8)) b8();
    mux_serializer_if #(.N(5)) b5();

    mux_serializer #(.N(8)) u8 (.clk(clk), .n_rst(n_rst), .bus(b8));
    mux_serializer #(.N(5)) u5 (.clk(clk), .n_rst(n_rst), .bus(b5));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       lv;
        logic [7:0] din;
        logic       msb;
        logic       br;
        logic       v;
        logic [2:0] ss;
        logic       o;
        logic       l;
        logic       lr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(logic lv, logic [7:0] din, logic msb,
                                logic br, logic v, logic [2:0] ss,
                                logic o, logic l, logic lr);
        vec_t e;
        e.lv = lv; e.din = din; e.msb = msb; e.br = br;
        e.v = v; e.ss = ss; e.o = o; e.l = l; e.lr = lr;
        tbl.push_back(e);
    endfunction

    // seq holds the expected bits in time order, first bit in seq[7].
    function automatic void add_word(logic [7:0] seq, logic msb, logic lv_n,
                                     logic [7:0] din_n, logic msb_n);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] s;
            logic lst;
            s = msb ? 3'(7 - i) : 3'(i);
            lst = (i == 7);
            add(lv_n, din_n, msb_n, 1'b1, 1'b1, s, seq[7-i], lst, lst);
        end
    endfunction

    function automatic logic mux_n(logic [4:0] x, logic [2:0] s);
        case (s)
            3'd0: return x[0];
            3'd1: return x[1];
            3'd2: return x[2];
            3'd3: return x[3];
            3'd4: return x[4];
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(logic lv, logic [7:0] din, logic msb, logic br);
        b8.load_valid = lv;
        b8.data_in = din;
        b8.msb_first = msb;
        b8.bit_ready = br;
    endtask

    logic q_bit[$];
    int   q_ss[$];

    initial begin
        drive8(0, 8'h00, 0, 0);
        b5.load_valid = 0;
        b5.data_in = '0;
        b5.msb_first = 0;
        b5.bit_ready = 0;

        // table: LSB-first, MSB-first, stall, back-to-back
        add(1, 8'hAC, 0, 1, 0, 0, 0, 0, 1);
        add_word(8'b00110101, 0, 0, 8'h00, 0);
        add(1, 8'hAC, 1, 1, 0, 7, 1, 0, 1);
        add_word(8'b10101100, 1, 0, 8'h00, 0);
        add(1, 8'hAC, 0, 1, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 1, 1, 1, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 2, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 2, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 2, 1, 0, 0);
        add(0, 8'h00, 0, 1, 1, 2, 1, 0, 0);
        add(0, 8'h00, 0, 1, 1, 3, 1, 0, 0);
        add(0, 8'h00, 0, 1, 1, 4, 0, 0, 0);
        add(0, 8'h00, 0, 1, 1, 5, 1, 0, 0);
        add(0, 8'h00, 0, 1, 1, 6, 0, 0, 0);
        add(0, 8'h00, 0, 1, 1, 7, 1, 1, 1);
        add(1, 8'hA5, 0, 1, 0, 7, 1, 0, 1);
        add_word(8'b10100101, 0, 1, 8'h3C, 0);
        add_word(8'b00111100, 0, 0, 8'h00, 0);
        add(0, 8'h00, 0, 1, 0, 7, 0, 0, 1);

        #2;
        chk("rst_valid", 32'(b8.bit_valid), 0);
        chk("rst_ready", 32'(b8.load_ready), 1);
        tick();
        tick();
        n_rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive8(tbl[i].lv, tbl[i].din, tbl[i].msb, tbl[i].br);
            #4;
            chk($sformatf("v%0d_valid", i), 32'(b8.bit_valid), 32'(tbl[i].v));
            chk($sformatf("v%0d_ss", i), 32'(b8.ss), 32'(tbl[i].ss));
            chk($sformatf("v%0d_out", i), 32'(b8.bit_out), 32'(tbl[i].o));
            chk($sformatf("v%0d_last", i), 32'(b8.bit_last), 32'(tbl[i].l));
            chk($sformatf("v%0d_lready", i), 32'(b8.load_ready), 32'(tbl[i].lr));
            tick();
        end

        // asynchronous reset in the middle of a word
        drive8(1, 8'hAC, 0, 1);
        tick();
        drive8(0, 8'h00, 0, 1);
        tick();
        tick();
        tick();
        chk("pre_rst_ss", 32'(b8.ss), 3);
        chk("pre_rst_valid", 32'(b8.bit_valid), 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_valid", 32'(b8.bit_valid), 0);
        chk("arst_ss", 32'(b8.ss), 0);
        chk("arst_data", 32'(b8.data_q), 0);
        chk("arst_lready", 32'(b8.load_ready), 1);
        chk("arst_out", 32'(b8.bit_out), 0);
        chk("arst_last", 32'(b8.bit_last), 0);
        tick();
        n_rst = 1'b1;
        drive8(1, 8'h3C, 1, 1);
        tick();
        drive8(0, 8'h00, 0, 1);
        #4;
        chk("fresh_valid", 32'(b8.bit_valid), 1);
        chk("fresh_ss", 32'(b8.ss), 7);
        chk("fresh_data", 32'(b8.data_q), 32'h3C);
        for (int i = 0; i < 8; i++) tick();
        chk("fresh_idle", 32'(b8.bit_valid), 0);

        // N=5: non-power-of-two select range
        b5.load_valid = 1;
        b5.data_in = 5'b10110;
        b5.msb_first = 0;
        b5.bit_ready = 1;
        tick();
        b5.load_valid = 0;
        for (int i = 0; i < 5; i++) begin
            logic [4:0] exp5;
            exp5 = 5'b10110;
            #4;
            chk($sformatf("n5_%0d_valid", i), 32'(b5.bit_valid), 1);
            chk($sformatf("n5_%0d_ss", i), 32'(b5.ss), 32'(i));
            chk($sformatf("n5_%0d_out", i), 32'(b5.bit_out), 32'(exp5[i]));
            chk($sformatf("n5_%0d_mux", i), 32'(b5.bit_out),
                32'(mux_n(b5.data_q, b5.ss)));
            chk($sformatf("n5_%0d_last", i), 32'(b5.bit_last), 32'(i == 4));
            tick();
        end
        #4;
        chk("n5_idle_valid", 32'(b5.bit_valid), 0);
        chk("n5_idle_ss", 32'(b5.ss), 4);
        chk("n5_idle_mux", 32'(b5.bit_out), 32'(mux_n(b5.data_q, b5.ss)));
        tick();

        // randomized run against a queue of expected (bit, index) pairs
        q_bit.delete();
        q_ss.delete();
        for (int c = 0; c < 400; c++) begin
            logic lv, msb, br, exp_lr;
            logic [7:0] din;
            lv = 1'($urandom_range(0, 1));
            msb = 1'($urandom_range(0, 1));
            br = ($urandom_range(0, 9) < 7);
            din = 8'($urandom);
            drive8(lv, din, msb, br);
            #4;
            exp_lr = (q_bit.size() == 0) || (q_bit.size() == 1 && br);
            chk("rnd_valid", 32'(b8.bit_valid), 32'(q_bit.size() != 0));
            chk("rnd_lready", 32'(b8.load_ready), 32'(exp_lr));
            if (q_bit.size() != 0) begin
                chk("rnd_out", 32'(b8.bit_out), 32'(q_bit[0]));
                chk("rnd_ss", 32'(b8.ss), 32'(q_ss[0]));
                chk("rnd_last", 32'(b8.bit_last), 32'(q_bit.size() == 1));
            end else begin
                chk("rnd_last_idle", 32'(b8.bit_last), 0);
            end
            @(posedge clk);
            if (q_bit.size() != 0 && br) begin
                void'(q_bit.pop_front());
                void'(q_ss.pop_front());
            end
            if (lv && exp_lr) begin
                for (int k = 0; k < 8; k++) begin
                    int idx;
                    idx = msb ? 7 - k : k;
                    q_bit.push_back(din[idx]);
                    q_ss.push_back(idx);
                end
            end
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_serializer.md
# mux_serializer

Parallel-to-serial front end for the parameterised N-to-1 multiplexer stage. Accepts an N-bit word over a valid/ready handshake, holds it in a register, and sequences the select index through all N positions, one bit per accepted output handshake. Drives `x`/`ss` of the downstream `muxN` directly (`data_q`, `ss`) and also presents the selected bit with its own valid/ready handshake.

## Interface
- `N`, default 8: word width and number of select positions; N ≥ 2, need not be a power of two.
- `SW`, default `$clog2(N)`: select width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  upstream word available.
- `load_ready`  out  1  block can accept a word this cycle.
- `data_in`  in  N  word to serialise.
- `msb_first`  in  1  bit order for the word, sampled only on a load handshake.
- `data_q`  out  N  registered word; drives `muxN.x`.
- `ss`  out  SW  current select index; drives `muxN.ss`.
- `bit_valid`  out  1  `bit_out` is valid.
- `bit_ready`  in  1  downstream accepts `bit_out`.
- `bit_out`  out  1  `data_q[ss]`; must equal the `muxN` output for the same `x`/`ss`.
- `bit_last`  out  1  high with `bit_valid` on the final bit of the word.

## Operation
- **States.** IDLE and SHIFT. Registers: state, `data_q`, `ss`, `dir` (latched `msb_first`).
- **Load handshake.** `load_ready` = IDLE, or (SHIFT && `bit_last` && `bit_ready`). A load occurs when `load_valid && load_ready`.
  - `data_q` takes `data_in`.
  - `dir` takes `msb_first`.
  - `ss` takes N-1 if `msb_first`, else 0.
  - State becomes SHIFT.
- **Output.** In SHIFT, `bit_valid`=1 and `bit_out`=`data_q[ss]`.
  - `bit_last`=1 when `ss` equals the final index: 0 if `dir`, else N-1.
  - In IDLE, `bit_valid`=0 and `bit_last`=0.
- **Bit handshake.** Occurs when `bit_valid && bit_ready`.
  - Not last: `ss` steps by +1 (`dir`=0) or -1 (`dir`=1).
  - Last with a simultaneous load: reload as above and stay in SHIFT (back-to-back).
  - Last with no load: go to IDLE. `ss` and `data_q` hold their values.
- **Stall.** `bit_ready`=0 holds `ss`, `data_q` and all outputs stable. `bit_out` must not change while `bit_valid` is high and not yet accepted.
- **Index range.** `ss` never leaves 0..N-1, including for non-power-of-two N; there is no wrap inside a word.
- **Ignored input.** `load_valid` in SHIFT when not last is ignored; upstream holds its word.

## Timing
- **Reset values** (immediately on `n_rst` low, asynchronous):
  - state IDLE, `data_q`=0, `ss`=0, `dir`=0.
  - `bit_valid`=0, `bit_last`=0, `bit_out`=0.
  - `load_ready`=1.
- **Latency.** Load at edge k puts the first bit on `bit_out` with `bit_valid`=1 from just after edge k; zero extra pipeline stages.
- **Throughput.** N bit handshakes per word. With `bit_ready` and `load_valid` held high, consecutive words stream with no idle cycle: N cycles per word.
- **Combinational outputs.** `load_ready`, `bit_out` and `bit_last` are combinational from registers and `bit_ready`. There is no path from `load_valid` to `load_ready`.
- **Reset mid-word.** The partial word is discarded. After `n_rst` rises, the block is in IDLE with reset values, and the next load starts a fresh word.
- **Simultaneous events.** A last-bit accept with a load on the same edge: the load wins and the state stays SHIFT.

## Test plan
- **Reset.** Assert `n_rst`=0 mid-SHIFT (N=8, `ss`=3). Required: `bit_valid`=0, `ss`=0 and `data_q`=0 immediately, with no clock edge needed; `load_ready`=1.
- **LSB-first.** Load 8'b10101100 with `msb_first`=0 and `bit_ready`=1. Required: `bit_out` = 0,0,1,1,0,1,0,1 on consecutive cycles, `ss` = 0..7, `bit_last` only at `ss`=7, then IDLE.
- **MSB-first.** Same word with `msb_first`=1. Required: `bit_out` = 1,0,1,0,1,1,0,0, `ss` = 7..0, `bit_last` at `ss`=0.
- **Stall.** Hold `bit_ready`=0 for 3 cycles at `ss`=2. Required: `ss`=2, `bit_out`=1 and `bit_valid`=1 stable throughout; resume at `ss`=3.
- **Back-to-back.** Load 8'hA5 then 8'h3C with `load_valid`=1 continuously. Required: `load_ready` pulses only on the last-bit cycle, 16 bits in 16 cycles, no gap.
- **Non-power-of-two.** Parameter N=5, load 5'b10110 LSB-first. Required: bits 0,1,1,0,1, `ss` max 4, then IDLE. Check `bit_out` equals the `muxN` #(5) output every cycle.
